mc_datapath: RTL and testbench

Multicycle MIPS datapath that consumes every control strobe from the multicycle controller FSM each cycle and returns the current opcode to it. Holds PC, IR, MDR, the A/B/ALUOut latches, the 32x32 register file, ALU control decode and the ALU. Drives one unified external instruction/data memory with a combinational read port.

---
 rtl/mips_mc_pkg.sv | 70 +++++++
 rtl/mc_regfile.sv | 33 +++
 rtl/mc_datapath.sv | 133 +++++++++++++
 tb/tb_mc_datapath.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mc_pkg.sv
// Shared definitions for the multicycle MIPS datapath.
// Holds the opcode and funct constants, the encodings of the controller
// selects (ALUOp, PCSource, ALUSrcB), the internal ALU operation enum, and
// the ALU-control decode function.
package mips_mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_ADD2  = 2'b11
  } aluop_e;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JUMP   = 2'b10,
    PCSRC_HOLD   = 2'b11
  } pcsrc_e;

  typedef enum logic [1:0] {
    SRCB_REG   = 2'b00,
    SRCB_FOUR  = 2'b01,
    SRCB_IMM   = 2'b10,
    SRCB_IMMSH = 2'b11
  } srcb_e;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT
  } alu_op_e;

  // ALUOp 00/11 add, 01 sub, 10 defers to the funct field; unknown funct adds.
  function automatic alu_op_e alu_decode(input logic [1:0] aluop,
                                         input logic [5:0] funct);
    alu_op_e op;
    op = ALU_ADD;
    case (aluop)
      ALUOP_SUB: op = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_SUB:  op = ALU_SUB;
          FN_AND:  op = ALU_AND;
          FN_OR:   op = ALU_OR;
          FN_SLT:  op = ALU_SLT;
          default: op = ALU_ADD;
        endcase
      end
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/mc_regfile.sv
// 32x32 general-purpose register file.
// Ports: clk_i, rst_ni (sync active-low clear of all registers),
//        we_i/waddr_i/wdata_i (one synchronous write port),
//        raddr1_i/rdata1_o, raddr2_i/rdata2_o (two asynchronous read ports).
// Register 0 always reads zero and ignores writes. No write-to-read bypass.
module mc_regfile (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr1_i,
  input  logic [4:0]  raddr2_i,
  output logic [31:0] rdata1_o,
  output logic [31:0] rdata2_o
);

  logic [31:0] regs_q [32];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != 5'd0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o = (raddr1_i == 5'd0) ? '0 : regs_q[raddr1_i];
  assign rdata2_o = (raddr2_i == 5'd0) ? '0 : regs_q[raddr2_i];

endmodule

// File: rtl/mc_datapath.sv
// Multicycle MIPS datapath: PC, IR, MDR, A/B/ALUOut latches, register file,
// ALU control decode and ALU. Driven entirely by the controller strobes.
// Ports:
//   clk, rst (sync active-low)
//   PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
//   RegWrite, RegDst, ALUSrcA (strobes); PCSource, ALUSrcB, ALUOp (selects)
//   opcode -> controller; mem_addr/mem_wdata/mem_we/mem_re/mem_rdata to the
//   unified memory (combinational read); pc, zero for observation.
module mc_datapath
  import mips_mc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCWriteCond,
  input  logic        PCWrite,
  input  logic        IorD,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        MemtoReg,
  input  logic        IRWrite,
  input  logic        RegWrite,
  input  logic        RegDst,
  input  logic        ALUSrcA,
  input  logic [1:0]  PCSource,
  input  logic [1:0]  ALUSrcB,
  input  logic [1:0]  ALUOp,
  output logic [5:0]  opcode,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [31:0] mem_rdata,
  output logic [31:0] pc,
  output logic        zero
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, mdr_q, a_q, b_q, aluout_q;
  logic [31:0] rf_rd1, rf_rd2;
  logic [31:0] sext_imm;
  logic [31:0] src_a, src_b, alu_result;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        pc_en;
  alu_op_e     alu_op;

  mc_regfile u_regfile (
    .clk_i    (clk),
    .rst_ni   (rst),
    .we_i     (RegWrite),
    .waddr_i  (rf_waddr),
    .wdata_i  (rf_wdata),
    .raddr1_i (ir_q[25:21]),
    .raddr2_i (ir_q[20:16]),
    .rdata1_o (rf_rd1),
    .rdata2_o (rf_rd2)
  );

  assign rf_waddr = RegDst ? ir_q[15:11] : ir_q[20:16];
  assign rf_wdata = MemtoReg ? mdr_q : aluout_q;
  assign sext_imm = {{16{ir_q[15]}}, ir_q[15:0]};

  always_comb begin
    src_a = ALUSrcA ? a_q : pc_q;
    src_b = b_q;
    case (ALUSrcB)
      SRCB_FOUR:  src_b = 32'd4;
      SRCB_IMM:   src_b = sext_imm;
      SRCB_IMMSH: src_b = {sext_imm[29:0], 2'b00};
      default:    src_b = b_q;
    endcase
  end

  assign alu_op = alu_decode(ALUOp, ir_q[5:0]);

  always_comb begin
    alu_result = '0;
    case (alu_op)
      ALU_SUB: alu_result = src_a - src_b;
      ALU_AND: alu_result = src_a & src_b;
      ALU_OR:  alu_result = src_a | src_b;
      ALU_SLT: alu_result = {31'd0, $signed(src_a) < $signed(src_b)};
      default: alu_result = src_a + src_b;
    endcase
  end

  assign zero = (alu_result == 32'd0);

  always_comb begin
    pc_d = pc_q;
    case (PCSource)
      PCSRC_ALU:    pc_d = alu_result;
      PCSRC_ALUOUT: pc_d = aluout_q;
      PCSRC_JUMP:   pc_d = {pc_q[31:28], ir_q[25:0], 2'b00};
      default:      pc_d = pc_q;
    endcase
  end

  assign pc_en = PCWrite | (PCWriteCond & zero);

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      mdr_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      aluout_q <= '0;
    end else begin
      if (pc_en) begin
        pc_q <= pc_d;
      end
      if (IRWrite) begin
        ir_q <= mem_rdata;
      end
      mdr_q    <= mem_rdata;
      a_q      <= rf_rd1;
      b_q      <= rf_rd2;
      aluout_q <= alu_result;
    end
  end

  assign opcode    = ir_q[31:26];
  assign mem_addr  = IorD ? aluout_q : pc_q;
  assign mem_wdata = b_q;
  // Strobes are masked by reset so an aborted instruction cannot write memory.
  assign mem_we    = MemWrite & rst;
  assign mem_re    = MemRead & rst;
  assign pc        = pc_q;

endmodule

// File: tb/tb_mc_datapath.sv
module tb_mc_datapath;

  logic        clk = 1'b0;
  logic        rst;
  logic        PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemtoReg;
  logic        IRWrite, RegWrite, RegDst, ALUSrcA;
  logic [1:0]  PCSource, ALUSrcB, ALUOp;
  logic [5:0]  opcode;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc;
  logic        mem_we, mem_re, zero;

  int n_vec  = 0;
  int n_miss = 0;
  logic [31:0] rv;

  always #5 clk = ~clk;

  mc_datapath #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .PCWriteCond(PCWriteCond), .PCWrite(PCWrite), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .RegDst(RegDst), .ALUSrcA(ALUSrcA),
    .PCSource(PCSource), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .opcode(opcode), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata),
    .pc(pc), .zero(zero)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    {PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemtoReg} = '0;
    {IRWrite, RegWrite, RegDst, ALUSrcA} = '0;
    PCSource = 2'b00; ALUSrcB = 2'b00; ALUOp = 2'b00;
  endtask

  task automatic load_ir(input logic [31:0] instr);
    idle();
    mem_rdata = instr;
    IRWrite = 1'b1;
    tick();
    idle();
  endtask

  // Reads a GPR through the B latch: IR.rt selects it, B captures, mem_wdata shows it.
  task automatic read_reg(input logic [4:0] r, output logic [31:0] v);
    load_ir({11'd0, r, 16'd0});
    tick();
    v = mem_wdata;
  endtask

  // Writes a GPR through the MDR path using an lw-shaped IR (rt = r).
  task automatic set_reg(input logic [4:0] r, input logic [31:0] v);
    load_ir({6'h23, 5'd0, r, 16'd0});
    mem_rdata = v;
    tick();
    mem_rdata = '0;
    RegWrite = 1'b1; MemtoReg = 1'b1; RegDst = 1'b0;
    tick();
    idle();
  endtask

  task automatic do_rtype(input logic [31:0] instr);
    load_ir(instr);
    tick();
    ALUSrcA = 1'b1; ALUSrcB = 2'b00; ALUOp = 2'b10;
    tick();
    idle();
    RegWrite = 1'b1; RegDst = 1'b1; MemtoReg = 1'b0;
    tick();
    idle();
  endtask

  task automatic fetch(input logic [31:0] instr);
    idle();
    mem_rdata = instr;
    MemRead = 1'b1; IRWrite = 1'b1; PCWrite = 1'b1;
    PCSource = 2'b00; ALUSrcA = 1'b0; ALUSrcB = 2'b01; ALUOp = 2'b00;
    tick();
    idle();
  endtask

  task automatic decode();
    idle();
    ALUSrcA = 1'b0; ALUSrcB = 2'b11; ALUOp = 2'b00;
    tick();
    idle();
  endtask

  initial begin
    mem_rdata = $urandom;
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      {PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemtoReg} = 6'($urandom);
      {IRWrite, RegWrite, RegDst, ALUSrcA} = 4'($urandom);
      {PCSource, ALUSrcB, ALUOp} = 6'($urandom);
      mem_rdata = $urandom;
      tick();
    end
    MemWrite = 1'b1; MemRead = 1'b1; IorD = 1'b0;
    #1;
    check("rst_pc", pc, 32'h0);
    check("rst_opcode", {26'd0, opcode}, 32'h0);
    check("rst_mem_we", {31'd0, mem_we}, 32'h0);
    check("rst_mem_re", {31'd0, mem_re}, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    idle();
    rst = 1'b1;
    for (int r = 0; r < 32; r++) begin
      read_reg(5'(r), rv);
      check($sformatf("rst_gpr%0d", r), rv, 32'h0);
    end

    // ADDI $1,$0,5 at pc 0
    idle();
    MemRead = 1'b1; #1;
    check("fetch_mem_re", {31'd0, mem_re}, 32'h1);
    check("fetch_mem_addr", mem_addr, 32'h0);
    fetch(32'h2001_0005);
    check("addi_opcode", {26'd0, opcode}, 32'h08);
    check("addi_pc", pc, 32'h4);
    decode();
    ALUSrcA = 1'b1; ALUSrcB = 2'b10; ALUOp = 2'b00;
    tick();
    idle();
    RegWrite = 1'b1;
    tick();
    idle();
    read_reg(5'd1, rv);
    check("addi_r1", rv, 32'h5);

    // lw $2,4($1) at pc 4
    fetch(32'h8C22_0004);
    check("lw_opcode", {26'd0, opcode}, 32'h23);
    check("lw_pc", pc, 32'h8);
    decode();
    ALUSrcA = 1'b1; ALUSrcB = 2'b10; ALUOp = 2'b00;
    tick();
    idle();
    IorD = 1'b1; MemRead = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    #1;
    check("lw_mem_addr", mem_addr, 32'h9);
    check("lw_mem_re", {31'd0, mem_re}, 32'h1);
    tick();
    idle();
    mem_rdata = '0;
    RegWrite = 1'b1; MemtoReg = 1'b1;
    tick();
    idle();
    read_reg(5'd2, rv);
    check("lw_r2", rv, 32'hDEAD_BEEF);
    read_reg(5'd0, rv);
    check("lw_r0", rv, 32'h0);

    // beq $0,$0,+3 at pc 8 -> taken to 24
    check("beq_pc_start", pc, 32'h8);
    fetch(32'h1000_0003);
    check("beq_opcode", {26'd0, opcode}, 32'h04);
    decode();
    ALUSrcA = 1'b1; ALUSrcB = 2'b00; ALUOp = 2'b01;
    PCWriteCond = 1'b1; PCSource = 2'b01;
    #1;
    check("beq_zero", {31'd0, zero}, 32'h1);
    tick();
    idle();
    check("beq_taken_pc", pc, 32'd24);

    // back to pc 8 via jump target 2, then beq $1,$0,+3 not taken
    load_ir(32'h0800_0002);
    PCWrite = 1'b1; PCSource = 2'b10;
    tick();
    idle();
    check("jmp_pc8", pc, 32'h8);
    fetch(32'h1020_0003);
    decode();
    ALUSrcA = 1'b1; ALUSrcB = 2'b00; ALUOp = 2'b01;
    PCWriteCond = 1'b1; PCSource = 2'b01;
    #1;
    check("bne_zero", {31'd0, zero}, 32'h0);
    tick();
    idle();
    check("beq_nt_pc", pc, 32'd12);

    // Jump with PC high nibble preserved
    set_reg(5'd4, 32'h4000_0010);
    load_ir(32'h0080_0000);
    tick();
    PCWrite = 1'b1; PCSource = 2'b00; ALUSrcA = 1'b1; ALUSrcB = 2'b00; ALUOp = 2'b00;
    tick();
    idle();
    check("pc_set", pc, 32'h4000_0010);
    load_ir(32'h0800_0010);
    check("j_opcode", {26'd0, opcode}, 32'h02);
    PCWrite = 1'b1; PCSource = 2'b10;
    tick();
    idle();
    check("j_pc", pc, 32'h4000_0040);

    // R-type
    set_reg(5'd1, 32'hFFFF_FFFF);
    set_reg(5'd2, 32'h5);
    do_rtype(32'h0022_182A);
    read_reg(5'd3, rv);
    check("slt_r3", rv, 32'h1);
    do_rtype(32'h0041_0022);
    read_reg(5'd0, rv);
    check("sub_r0", rv, 32'h0);
    do_rtype(32'h0041_4022);
    read_reg(5'd8, rv);
    check("sub_r8", rv, 32'h6);
    do_rtype(32'h0022_4824);
    read_reg(5'd9, rv);
    check("and_r9", rv, 32'h5);
    do_rtype(32'h0041_5025);
    read_reg(5'd10, rv);
    check("or_r10", rv, 32'hFFFF_FFFF);
    do_rtype(32'h0041_582A);
    read_reg(5'd11, rv);
    check("slt_r11", rv, 32'h0);
    set_reg(5'd5, 32'h7FFF_FFFF);
    set_reg(5'd6, 32'h1);
    do_rtype(32'h00A6_3820);
    read_reg(5'd7, rv);
    check("add_ovf_r7", rv, 32'h8000_0000);
    do_rtype(32'h00A6_603F);
    read_reg(5'd12, rv);
    check("badfn_add_r12", rv, 32'h8000_0000);

    // Reset mid-instruction: write strobes must not take effect
    load_ir(32'h00A6_3820);
    RegWrite = 1'b1; RegDst = 1'b1; MemWrite = 1'b1; PCWrite = 1'b1;
    rst = 1'b0;
    #1;
    check("midrst_mem_we", {31'd0, mem_we}, 32'h0);
    tick();
    idle();
    rst = 1'b1;
    check("midrst_pc", pc, 32'h0);
    check("midrst_opcode", {26'd0, opcode}, 32'h0);
    read_reg(5'd7, rv);
    check("midrst_r7", rv, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
